// File: rtl/hazard_stall_control.sv
// Stall/flush controller for the LC-3b five-stage pipeline.
// Produces the per-stage register enables and bubble/flush selects that
// keep the pipeline consistent across load-use hazards, instruction and data
// memory waits and taken branches. It also counts the cycles in which the
// PC does not advance.
module hazard_stall_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [2:0]       id_sr1,
  input  logic [2:0]       id_sr2,
  input  logic             id_sr1_used,
  input  logic             id_sr2_used,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [2:0]       ex_dest,
  input  logic             imem_wait,
  input  logic             imem_resp,
  input  logic             mem_access,
  input  logic             dmem_resp,
  input  logic             br_taken,
  output logic             pc_load,
  output logic             if_id_load,
  output logic             id_ex_load,
  output logic             ex_mem_load,
  output logic             mem_wb_load,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic             mem_wb_bubble,
  output logic             target_latch,
  output logic             pc_redirect,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    IWAIT = 2'd2,
    REDIR = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t state_reg;
  state_t state_next;

  logic dstall;
  logic istall;
  logic lu;
  logic sr1_hit;
  logic sr2_hit;

  assign dstall  = mem_access & ~dmem_resp;
  assign istall  = imem_wait & ~imem_resp;
  assign sr1_hit = id_sr1_used & (id_sr1 == ex_dest);
  assign sr2_hit = id_sr2_used & (id_sr2 == ex_dest);
  assign lu      = id_valid & ex_valid & ex_is_load & (sr1_hit | sr2_hit);

  // State register; reset drops any pending redirect immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state selection. A data stall freezes everything, including a
  // pending redirect, so REDIR survives a data wait.
  always_comb begin
    state_next = state_reg;
    if (state_reg == REDIR) begin
      if (dstall) begin
        state_next = REDIR;
      end else if (imem_resp) begin
        state_next = RUN;
      end else begin
        state_next = REDIR;
      end
    end else if (dstall) begin
      state_next = DWAIT;
    end else if (br_taken && !istall) begin
      state_next = RUN;
    end else if (br_taken) begin
      state_next = REDIR;
    end else if (istall) begin
      state_next = IWAIT;
    end else begin
      state_next = RUN;
    end
  end

  // Output decode: priority chain over reset, data stall, redirect,
  // branch, load-use and fetch wait. DWAIT/IWAIT decode like RUN so the
  // response cycle advances the whole pipeline.
  always_comb begin
    pc_load       = 1'b1;
    if_id_load    = 1'b1;
    id_ex_load    = 1'b1;
    ex_mem_load   = 1'b1;
    mem_wb_load   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    mem_wb_bubble = 1'b0;
    target_latch  = 1'b0;
    pc_redirect   = 1'b0;
    if (reset) begin
      pc_load       = 1'b0;
      if_id_load    = 1'b0;
      id_ex_load    = 1'b0;
      ex_mem_load   = 1'b0;
      mem_wb_load   = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (dstall) begin
      pc_load       = 1'b0;
      if_id_load    = 1'b0;
      id_ex_load    = 1'b0;
      ex_mem_load   = 1'b0;
      mem_wb_load   = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (state_reg == REDIR) begin
      // IF/ID still holds a wrong-path instruction, so ID/EX keeps
      // receiving bubbles until the redirected fetch is under way.
      id_ex_bubble = 1'b1;
      if (imem_resp) begin
        pc_redirect = 1'b1;
        if_id_flush = 1'b1;
      end else begin
        pc_load    = 1'b0;
        if_id_load = 1'b0;
      end
    end else if (br_taken && !istall) begin
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
    end else if (br_taken) begin
      target_latch  = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
      pc_load       = 1'b0;
      if_id_load    = 1'b0;
    end else if (lu || istall) begin
      pc_load      = 1'b0;
      if_id_load   = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  // Saturating count of cycles in which the PC is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (!pc_load && (stall_cycles != CNT_MAX)) begin
      stall_cycles <= stall_cycles + CNT_ONE;
    end
  end

endmodule

// File: doc/hazard_stall_control.md
# hazard_stall_control

Pipeline-wide stall and flush controller for the LC-3b five-stage pipeline. It sits beside the ID/EX boundary, directly upstream of the EX-stage forwarding unit. It guarantees that every operand pair reaching EX can be satisfied by EX/MEM or MEM/WB forwarding, by inserting a load-use bubble. It also freezes the pipeline on instruction and data memory waits, squashes wrong-path instructions on taken branches, and keeps a saturating stall-cycle counter.

## Interface
Parameters:
- CNT_W, 16, width of the stall-cycle counter

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high
- id_valid  in  1  ID stage holds a real instruction
- id_sr1, id_sr2  in  lc3b_reg  source registers decoded in ID
- id_sr1_used, id_sr2_used  in  1  the corresponding source is actually read
- ex_valid  in  1  EX stage holds a real instruction
- ex_is_load  in  1  EX instruction reads data memory and writes the register file (LDR, LDB, LDI)
- ex_dest  in  lc3b_reg  EX destination register
- imem_wait  in  1  instruction fetch outstanding
- imem_resp  in  1  instruction memory response this cycle
- mem_access  in  1  MEM instruction accesses data memory
- dmem_resp  in  1  data memory response this cycle
- br_taken  in  1  MEM stage resolved a taken branch, JMP, JSR or TRAP
- pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load  out  1 each  register enables
- if_id_flush, id_ex_bubble, ex_mem_bubble, mem_wb_bubble  out  1 each  load a NOP/invalid entry instead of the upstream value
- target_latch  out  1  capture the branch target into the pending-target register
- pc_redirect  out  1  PC mux selects the pending-target register
- stall_cycles  out  CNT_W  saturating count of cycles with pc_load = 0

## Operation
- FSM states:
  - RUN
  - DWAIT (data memory wait)
  - IWAIT (fetch wait)
  - REDIR (fetch wait with a redirect pending)
- Signal definitions:
  - dstall = mem_access & ~dmem_resp
  - istall = imem_wait & ~imem_resp
  - lu = id_valid & ex_valid & ex_is_load & ((id_sr1_used & id_sr1 == ex_dest) | (id_sr2_used & id_sr2 == ex_dest))
- Priority, highest first:
  - Data stall: all four stage loads and pc_load are 0; mem_wb_bubble = 1. br_taken is ignored because MEM is frozen and the branch stays visible. Next state DWAIT, or REDIR if a redirect is already pending.
  - Branch taken, no fetch wait: pc_load = 1; if_id_flush = id_ex_bubble = ex_mem_bubble = 1; all loads 1. Next state RUN.
  - Branch taken during a fetch wait: target_latch = 1; id_ex_bubble = ex_mem_bubble = 1; pc_load = if_id_load = 0; ex_mem_load = mem_wb_load = 1. Next state REDIR.
  - Load-use hazard: pc_load = if_id_load = 0; id_ex_bubble = 1; downstream loads 1. Exactly one bubble is inserted per hazard.
  - Fetch wait: same outputs as load-use. Next state IWAIT.
  - Otherwise: all loads 1, no bubbles.
- REDIR behaviour:
  - Any fetch data returned is wrong-path.
  - On imem_resp: pc_load = 1, pc_redirect = 1, if_id_flush = 1. Next state RUN.
  - Before imem_resp: upstream is held and id_ex_bubble = 1.
  - A second br_taken while in REDIR cannot occur, because EX and MEM hold bubbles.
- Leaving DWAIT/IWAIT: the response cycle behaves as RUN (full advance).
- stall_cycles increments on every clock edge where pc_load = 0, saturates at all-ones, and does not wrap.

## Timing
- Outputs are combinational from inputs and state, with zero latency. State and the counter are registered.
- While reset is asserted:
  - All loads are 0; all bubble/flush outputs are 1.
  - target_latch = pc_redirect = 0.
  - State is RUN and stall_cycles = 0, both taking effect immediately (asynchronous).
- Reset mid-wait discards any pending redirect; there is no recovery of the target.
- Memory response cycles:
  - A dmem_resp arriving in the same cycle as mem_access gives no stall.
  - A fetch response arriving together with lu still bubbles for lu.
- Load-use timing: the bubble cycle is followed by the load in MEM/WB. The dependent instruction's operand is then served by the MEM/WB forward path, with no second bubble.
- Simultaneous dstall and istall: dstall dominates. Fetch progress resumes once the data access completes.

## Test plan
- LDR R2 in EX, ADD R3,R2,R1 in ID (sr1_used = 1) -> one cycle with pc_load = 0 and id_ex_bubble = 1; next cycle all loads 1; stall_cycles = 1.
- Same pair but the ADD uses sr2 = R2 with sr2_used = 0 -> no bubble; stall_cycles stays 0.
- mem_access = 1 with dmem_resp low for 3 cycles -> 3 cycles with all loads 0 and mem_wb_bubble = 1; on the 4th cycle full advance; stall_cycles = 3.
- br_taken with imem_wait = 0 -> if_id_flush, id_ex_bubble and ex_mem_bubble all 1 and pc_load = 1 in the same cycle; state RUN.
- br_taken while imem_wait = 1 and imem_resp = 0, response 2 cycles later -> target_latch pulses once; then pc_redirect = 1 with if_id_flush = 1 in the response cycle.
- Preload CNT_W = 4 and stall 20 cycles -> stall_cycles = 15 and holds; assert reset mid-stall -> outputs take the reset values immediately and stall_cycles = 0.
